// File: rtl/uart_rx_os_if.sv
// Byte-side handshake bundle of the oversampled UART receiver.
// master = receiver (produces bytes), slave = consumer.
interface uart_rx_os_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_frame_err;
  logic                  o_overrun;

  modport master (output o_data, o_valid, o_frame_err, o_overrun, input i_ready);
  modport slave  (input o_data, o_valid, o_frame_err, o_overrun, output i_ready);
endinterface

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver, 16x oversampled, 3-sample majority vote per bit,
// start-bit validation, framing-error and overrun pulses, valid/ready byte output.
module uart_rx_os #(
  parameter int DIVIDER_BITWIDTH = 7,
  parameter int CLKS_PER_TICK    = 65,
  parameter int DATA_WIDTH       = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rx,
  uart_rx_os_if.master rx_if
);
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_e;

  state_e                      state_q;
  logic                        rx_meta_q, rx_s_q, rx_prev_q;
  logic [DIVIDER_BITWIDTH-1:0] div_q;
  logic [3:0]                  smp_q, bit_q, idle_cnt_q;
  logic                        s7_q, s8_q;
  logic [DATA_WIDTH-1:0]       shift_q, byte_q, data_q;
  logic                        done_q, valid_q, frame_err_q, overrun_q;
  logic                        tick, decide, maj;

  assign tick   = (div_q == DIVIDER_BITWIDTH'(CLKS_PER_TICK - 1));
  assign decide = tick && (smp_q == 4'd9);
  // Samples 7 and 8 are latched; sample 9 is taken live on the deciding tick.
  assign maj    = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= WAIT_IDLE;
      div_q       <= '0;
      smp_q       <= '0;
      bit_q       <= '0;
      idle_cnt_q  <= '0;
      s7_q        <= 1'b0;
      s8_q        <= 1'b0;
      shift_q     <= '0;
      byte_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      div_q       <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        smp_q <= smp_q + 4'd1;
        if (smp_q == 4'd15) bit_q <= bit_q + 4'd1;
        if (smp_q == 4'd7)  s7_q  <= rx_s_q;
        if (smp_q == 4'd8)  s8_q  <= rx_s_q;
      end
      case (state_q)
        WAIT_IDLE: begin
          if (!rx_s_q) begin
            idle_cnt_q <= '0;
          end else if (tick) begin
            if (idle_cnt_q == 4'd15) begin
              idle_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + 4'd1;
            end
          end
        end
        IDLE: begin
          // Holding the counters at zero here doubles as the clear on start detection.
          div_q <= '0;
          smp_q <= '0;
          bit_q <= '0;
          if (!rx_s_q && rx_prev_q) state_q <= START;
        end
        START: if (decide) state_q <= maj ? IDLE : DATA;
        DATA: begin
          if (decide) begin
            shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
            if (bit_q == 4'(DATA_WIDTH)) state_q <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (maj) begin
              byte_q  <= shift_q;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              idle_cnt_q  <= '0;
              state_q     <= WAIT_IDLE;
            end
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  // A completed byte only overwrites the holding register if the old one is gone
  // or leaves on this same edge; otherwise it is dropped and flagged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || rx_if.i_ready) begin
          data_q  <= byte_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_if.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = frame_err_q;
  assign rx_if.o_overrun   = overrun_q;
endmodule
